// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and constants for the forwarding/hazard control block.
// Forward-select encodings, shadow-stage record and FSM states.
package fwd_pkg;

    localparam int FWD_REG_ADDR_W = 5;
    localparam int FWD_SEL_W      = 2;

    localparam logic [FWD_SEL_W-1:0] FWD_REGFILE = 2'b00;
    localparam logic [FWD_SEL_W-1:0] FWD_EXMEM   = 2'b01;
    localparam logic [FWD_SEL_W-1:0] FWD_MEMWB   = 2'b10;

    typedef struct packed {
        logic                      valid;
        logic [FWD_REG_ADDR_W-1:0] dst;
        logic                      regwrite;
        logic                      memread;
    } stage_info_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request bundle and forward/stall responses for fwd_hazard_ctrl.
// StallCount is present only when STALL_COUNTER_EN is defined.
interface fwd_hazard_ctrl_if
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = FWD_REG_ADDR_W,
    parameter int SEL_W      = FWD_SEL_W
);

    logic                  IdValid;
    logic [REG_ADDR_W-1:0] IdRs;
    logic [REG_ADDR_W-1:0] IdRt;
    logic                  IdUsesRs;
    logic                  IdUsesRt;
    logic [REG_ADDR_W-1:0] IdDst;
    logic                  IdRegWrite;
    logic                  IdMemRead;
    logic                  Flush;
    logic [SEL_W-1:0]      FwdASel;
    logic [SEL_W-1:0]      FwdBSel;
    logic                  Stall;
    logic                  Bubble;
`ifdef STALL_COUNTER_EN
    logic [31:0]           StallCount;

    modport master (
        output IdValid, IdRs, IdRt, IdUsesRs, IdUsesRt, IdDst, IdRegWrite, IdMemRead, Flush,
        input  FwdASel, FwdBSel, Stall, Bubble, StallCount
    );

    modport slave (
        input  IdValid, IdRs, IdRt, IdUsesRs, IdUsesRt, IdDst, IdRegWrite, IdMemRead, Flush,
        output FwdASel, FwdBSel, Stall, Bubble, StallCount
    );
`else
    modport master (
        output IdValid, IdRs, IdRt, IdUsesRs, IdUsesRt, IdDst, IdRegWrite, IdMemRead, Flush,
        input  FwdASel, FwdBSel, Stall, Bubble
    );

    modport slave (
        input  IdValid, IdRs, IdRt, IdUsesRs, IdUsesRt, IdDst, IdRegWrite, IdMemRead, Flush,
        output FwdASel, FwdBSel, Stall, Bubble
    );
`endif

endinterface

// File: rtl/fwd_hazard_ctrl_sel_compare.sv
// Per-operand forward-select priority comparator (purely combinational).
// The EX-stage producer is younger than the MEM-stage one, so it wins.
module fwd_sel_compare
    import fwd_pkg::*;
(
    input  logic [FWD_REG_ADDR_W-1:0] src,
    input  logic                      uses,
    input  stage_info_t               exStage,
    input  stage_info_t               memStage,
    output logic [FWD_SEL_W-1:0]      sel
);

    logic exHit;
    logic memHit;

    assign exHit  = exStage.valid  && exStage.regwrite  && (exStage.dst  == src);
    assign memHit = memStage.valid && memStage.regwrite && (memStage.dst == src);

    // Register 0 is hard-wired, so it is never forwarded even if a stage "writes" it.
    always_comb begin
        sel = FWD_REGFILE;
        if (!uses || (src == '0)) begin
            sel = FWD_REGFILE;
        end else if (exHit) begin
            sel = FWD_EXMEM;
        end else if (memHit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller beside the ID/EX register.
// Optional: define STALL_COUNTER_EN to add a saturating 32-bit StallCount output.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = FWD_REG_ADDR_W,
    parameter int SEL_W      = FWD_SEL_W
)
(
    input  logic             Clk,
    input  logic             Reset,
    fwd_hazard_ctrl_if.slave bus
);

    stage_info_t           exStage;
    stage_info_t           memStage;
    stage_info_t           wbStage;
    stage_info_t           idStage;
    fsm_state_t            state;
    fsm_state_t            nextState;
    logic                  hazard;
    logic                  stallInt;
    logic                  bubbleInt;
    logic                  advance;
    logic [REG_ADDR_W-1:0] exDst;
    logic [SEL_W-1:0]      selANext;
    logic [SEL_W-1:0]      selBNext;
    logic [SEL_W-1:0]      selAReg;
    logic [SEL_W-1:0]      selBReg;

    assign exDst = exStage.dst;

    assign hazard = bus.IdValid && exStage.valid && exStage.memread && (exDst != '0) &&
                    ((bus.IdUsesRs && (bus.IdRs == exDst)) ||
                     (bus.IdUsesRt && (bus.IdRt == exDst)));

    always_comb begin
        idStage          = '0;
        idStage.valid    = 1'b1;
        idStage.dst      = bus.IdDst;
        idStage.regwrite = bus.IdRegWrite;
        idStage.memread  = bus.IdMemRead;
    end

    // In STALL the load has moved to MEM and EX holds the bubble, so no re-check is needed.
    always_comb begin
        nextState = state;
        stallInt  = 1'b0;
        bubbleInt = bus.Flush || !bus.IdValid;
        case (state)
            RUN: begin
                if (hazard && !bus.Flush) begin
                    stallInt  = 1'b1;
                    bubbleInt = 1'b1;
                    nextState = STALL;
                end
            end
            STALL: begin
                nextState = RUN;
            end
            default: begin
                nextState = RUN;
            end
        endcase
        if (Reset) begin
            stallInt  = 1'b0;
            bubbleInt = 1'b0;
        end
    end

    assign advance = bus.IdValid && !stallInt && !bus.Flush;

    fwd_sel_compare uCmpA (
        .src      (bus.IdRs),
        .uses     (bus.IdUsesRs),
        .exStage  (exStage),
        .memStage (memStage),
        .sel      (selANext)
    );

    fwd_sel_compare uCmpB (
        .src      (bus.IdRt),
        .uses     (bus.IdUsesRt),
        .exStage  (exStage),
        .memStage (memStage),
        .sel      (selBNext)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= RUN;
            exStage  <= '0;
            memStage <= '0;
            wbStage  <= '0;
            selAReg  <= FWD_REGFILE;
            selBReg  <= FWD_REGFILE;
        end else begin
            state    <= nextState;
            wbStage  <= memStage;
            memStage <= exStage;
            exStage  <= advance ? idStage : '0;
            selAReg  <= advance ? selANext : FWD_REGFILE;
            selBReg  <= advance ? selBNext : FWD_REGFILE;
        end
    end

    // Empty slots are always fully zeroed, which keeps stale dst bits from ever matching.
    assert property (@(posedge Clk) disable iff (Reset) !wbStage.valid |-> (wbStage == '0));

    assign bus.FwdASel = selAReg;
    assign bus.FwdBSel = selBReg;
    assign bus.Stall   = stallInt;
    assign bus.Bubble  = bubbleInt;

`ifdef STALL_COUNTER_EN
    logic [31:0] stallCount;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stallCount <= '0;
        end else if (stallInt && (stallCount != 32'hFFFF_FFFF)) begin
            stallCount <= stallCount + 32'd1;
        end
    end

    assign bus.StallCount = stallCount;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed table-driven bench for fwd_hazard_ctrl: forwarding, load-use stalls,
// flush priority and reset during STALL.
module tb_fwd_hazard_ctrl;

    typedef struct {
        string      name;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRs;
        logic       usesRt;
        logic [4:0] dst;
        logic       regWrite;
        logic       memRead;
        logic       flush;
        logic       expStall;
        logic       expBubble;
        logic [1:0] expA;
        logic [1:0] expB;
    } vec_t;

    logic Clk;
    logic Reset;
    int   compared;
    int   mismatched;
    int   expCount;
    vec_t vecs[24];
    vec_t nopVec;
    vec_t lwVec;
    vec_t useVec;
    vec_t indepVec;

    fwd_hazard_ctrl_if bus ();

    fwd_hazard_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic vec_t mk(string n, int va, int rs, int rt, int ur, int ut, int d,
                                int rw, int mr, int fl, int es, int eb, int ea, int ebs);
        vec_t v;
        v.name      = n;
        v.valid     = (va != 0);
        v.rs        = rs[4:0];
        v.rt        = rt[4:0];
        v.usesRs    = (ur != 0);
        v.usesRt    = (ut != 0);
        v.dst       = d[4:0];
        v.regWrite  = (rw != 0);
        v.memRead   = (mr != 0);
        v.flush     = (fl != 0);
        v.expStall  = (es != 0);
        v.expBubble = (eb != 0);
        v.expA      = ea[1:0];
        v.expB      = ebs[1:0];
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.IdValid    = v.valid;
        bus.IdRs       = v.rs;
        bus.IdRt       = v.rt;
        bus.IdUsesRs   = v.usesRs;
        bus.IdUsesRt   = v.usesRt;
        bus.IdDst      = v.dst;
        bus.IdRegWrite = v.regWrite;
        bus.IdMemRead  = v.memRead;
        bus.Flush      = v.flush;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        expCount   = 0;

        //             name            va rs rt ur ut dst rw mr fl  st bu  A  B
        vecs[0]  = mk("add3",          1, 1, 2, 1, 1, 3,  1, 0, 0,  0, 0, 0, 0);
        vecs[1]  = mk("sub4_exfwdA",   1, 3, 5, 1, 1, 4,  1, 0, 0,  0, 0, 1, 0);
        vecs[2]  = mk("add3b",         1, 1, 2, 1, 1, 3,  1, 0, 0,  0, 0, 0, 0);
        vecs[3]  = mk("nop",           1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
        vecs[4]  = mk("or6_memfwdB",   1, 7, 3, 1, 1, 6,  1, 0, 0,  0, 0, 0, 2);
        vecs[5]  = mk("add0",          1, 1, 2, 1, 1, 0,  1, 0, 0,  0, 0, 0, 0);
        vecs[6]  = mk("sub_r0",        1, 0, 0, 1, 1, 4,  1, 0, 0,  0, 0, 0, 0);
        vecs[7]  = mk("lw8",           1, 9, 8, 1, 0, 8,  1, 1, 0,  0, 0, 0, 0);
        vecs[8]  = mk("add10_hazard",  1, 8, 8, 1, 1, 10, 1, 0, 0,  1, 1, 0, 0);
        vecs[9]  = mk("add10_resume",  1, 8, 8, 1, 1, 10, 1, 0, 0,  0, 0, 2, 2);
        vecs[10] = mk("add11_exfwdA",  1, 10,13,1, 1, 11, 1, 0, 0,  0, 0, 1, 0);
        vecs[11] = mk("lw8b",          1, 9, 8, 1, 0, 8,  1, 1, 0,  0, 0, 0, 0);
        vecs[12] = mk("add10_flush",   1, 8, 1, 1, 1, 10, 1, 0, 1,  0, 1, 0, 0);
        vecs[13] = mk("add14_memfwd",  1, 8, 1, 1, 1, 14, 1, 0, 0,  0, 0, 2, 0);
        vecs[14] = mk("lw8c",          1, 9, 8, 1, 0, 8,  1, 1, 0,  0, 0, 0, 0);
        vecs[15] = mk("lw9_hazard",    1, 8, 9, 1, 0, 9,  1, 1, 0,  1, 1, 0, 0);
        vecs[16] = mk("lw9_resume",    1, 8, 9, 1, 0, 9,  1, 1, 0,  0, 0, 2, 0);
        vecs[17] = mk("add2_hazard",   1, 9, 0, 1, 1, 2,  1, 0, 0,  1, 1, 0, 0);
        vecs[18] = mk("add2_resume",   1, 9, 0, 1, 1, 2,  1, 0, 0,  0, 0, 2, 0);
        vecs[19] = mk("idle",          0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0);
        vecs[20] = mk("add5a",         1, 1, 1, 1, 1, 5,  1, 0, 0,  0, 0, 0, 0);
        vecs[21] = mk("add5b_nowb",    1, 2, 2, 1, 1, 5,  1, 0, 0,  0, 0, 0, 0);
        vecs[22] = mk("sub6_youngest", 1, 5, 5, 1, 1, 6,  1, 0, 0,  0, 0, 1, 1);
        vecs[23] = mk("or7_mixed",     1, 5, 6, 1, 1, 7,  1, 0, 0,  0, 0, 2, 1);

        nopVec   = mk("nop",           1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
        lwVec    = mk("lw8",           1, 9, 8, 1, 0, 8,  1, 1, 0,  0, 0, 0, 0);
        useVec   = mk("add10",         1, 8, 8, 1, 1, 10, 1, 0, 0,  1, 1, 0, 0);
        indepVec = mk("add11",         1, 12,13,1, 1, 11, 1, 0, 0,  0, 0, 0, 0);

        Reset = 1'b1;
        applyStimulus(lwVec);
        @(posedge Clk);
        #1;
        checkOutput("reset_stall", {31'd0, bus.Stall}, 32'd0);
        checkOutput("reset_bubble", {31'd0, bus.Bubble}, 32'd0);
        applyStimulus(nopVec);
        @(posedge Clk);
        #1;
        checkOutput("reset_selA", {30'd0, bus.FwdASel}, 32'd0);
        checkOutput("reset_selB", {30'd0, bus.FwdBSel}, 32'd0);
`ifdef STALL_COUNTER_EN
        checkOutput("reset_count", bus.StallCount, 32'd0);
`endif
        Reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput({vecs[i].name, "_stall"}, {31'd0, bus.Stall}, {31'd0, vecs[i].expStall});
            checkOutput({vecs[i].name, "_bubble"}, {31'd0, bus.Bubble}, {31'd0, vecs[i].expBubble});
            @(posedge Clk);
            #1;
            if (vecs[i].expStall) expCount++;
            checkOutput({vecs[i].name, "_selA"}, {30'd0, bus.FwdASel}, {30'd0, vecs[i].expA});
            checkOutput({vecs[i].name, "_selB"}, {30'd0, bus.FwdBSel}, {30'd0, vecs[i].expB});
`ifdef STALL_COUNTER_EN
            checkOutput({vecs[i].name, "_count"}, bus.StallCount, expCount);
`endif
        end

        // Reset arriving while the FSM sits in STALL.
        applyStimulus(lwVec);
        @(posedge Clk);
        #1;
        applyStimulus(useVec);
        #1;
        checkOutput("midstall_pre_stall", {31'd0, bus.Stall}, 32'd1);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        checkOutput("midstall_reset_stall", {31'd0, bus.Stall}, 32'd0);
        checkOutput("midstall_reset_bubble", {31'd0, bus.Bubble}, 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        checkOutput("midstall_selA", {30'd0, bus.FwdASel}, 32'd0);
        checkOutput("midstall_selB", {30'd0, bus.FwdBSel}, 32'd0);
`ifdef STALL_COUNTER_EN
        checkOutput("midstall_count", bus.StallCount, 32'd0);
`endif
        #1;
        checkOutput("postreset_stall", {31'd0, bus.Stall}, 32'd0);
        checkOutput("postreset_bubble", {31'd0, bus.Bubble}, 32'd0);
        @(posedge Clk);
        #1;
        checkOutput("postreset_selA", {30'd0, bus.FwdASel}, 32'd0);
        checkOutput("postreset_selB", {30'd0, bus.FwdBSel}, 32'd0);
        applyStimulus(indepVec);
        @(posedge Clk);
        #1;
        checkOutput("indep_selA", {30'd0, bus.FwdASel}, 32'd0);
        checkOutput("indep_selB", {30'd0, bus.FwdBSel}, 32'd0);
        checkOutput("indep_stall", {31'd0, bus.Stall}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Generates the 2-bit select codes that drive the EX-stage 32-bit 3:1 operand muxes for ALU inputs A and B.
- Detects load-use hazards and issues a one-cycle stall/bubble.
- Keeps its own shadow pipeline of destination-register info for the EX, MEM and WB stages, so selects are registered and ready at the start of the consumer's EX cycle.
- Sits beside the ID/EX pipeline register in the 5-stage MIPS datapath.

Parameters:
- REG_ADDR_W, 5: register-specifier width.
- SEL_W, 2: mux select width. Encoding fixed: 00 = register-file operand, 01 = EX/MEM ALU result, 10 = MEM/WB write-back data, 11 = never driven.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- IdValid  in  1  ID holds a real instruction.
- IdRs  in  REG_ADDR_W  source register A of the ID instruction.
- IdRt  in  REG_ADDR_W  source register B of the ID instruction.
- IdUsesRs  in  1  instruction reads Rs.
- IdUsesRt  in  1  instruction reads Rt.
- IdDst  in  REG_ADDR_W  destination register, post RegDst mux.
- IdRegWrite  in  1  instruction writes the register file.
- IdMemRead  in  1  instruction is a load.
- Flush  in  1  kill the ID instruction (taken branch/jump).
- FwdASel  out  SEL_W  registered select for the ALU-A mux.
- FwdBSel  out  SEL_W  registered select for the ALU-B mux.
- Stall  out  1  combinational: hold PC and IF/ID this cycle.
- Bubble  out  1  combinational: load a NOP into ID/EX this cycle.

Behaviour:
- Reset (sync, next rising edge):
  - Shadow stages EX/MEM/WB are invalid; dst = 0; RegWrite = 0; MemRead = 0.
  - FwdASel = FwdBSel = 00.
  - FSM = RUN.
  - Stall and Bubble evaluate to 0.
- Shadow pipeline, advancing every cycle:
  - WB <= MEM, and MEM <= EX, unconditionally.
  - EX <= ID when IdValid && !Stall && !Flush; otherwise EX <= invalid (bubble).
- Select generation, registered when ID advances into EX; computed for Rs→A and Rt→B independently:
  - Source reg is 0, or not used → 00.
  - Else if it matches EX-stage dst with RegWrite valid → 01. That producer is in MEM next cycle.
  - Else if it matches MEM-stage dst with RegWrite valid → 10.
  - Else → 00.
  - The youngest producer wins. The register file is write-first, so no forwarding from the WB stage itself.
  - On a bubble cycle (Stall or Flush or !IdValid), both selects are loaded with 00.
- Load-use hazard: IdValid && EX valid && EX MemRead && EX dst != 0 && ((IdUsesRs && IdRs == EX dst) || (IdUsesRt && IdRt == EX dst)).
- FSM:
  - RUN: on hazard && !Flush, assert Stall = Bubble = 1 and go to STALL. Otherwise Stall = 0 and Bubble = Flush || !IdValid.
  - STALL: Stall = 0. The load is now in MEM and EX holds the bubble, so the hazard cannot re-fire. Registered select resolves to 10. Return to RUN unconditionally.
- Simultaneous events:
  - Flush beats hazard: no stall, bubble inserted, FSM stays RUN.
  - Reset beats everything.
  - Reset mid-STALL returns to RUN with cleared shadows.
- A double load-use (load immediately followed by a dependent load) stalls exactly once per consumer.

Optional Feature:
- STALL_COUNTER_EN defined:
  - Adds output port StallCount (32 bits).
  - Increments on each cycle Stall = 1 and saturates at 0xFFFFFFFF.
  - Cleared by Reset.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package fwd_pkg holds:
  - Select constants FWD_REGFILE = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10.
  - Stage-info struct {valid, dst, regwrite, memread}.
  - FSM state enum {RUN, STALL}.
- One sub-module, fwd_sel_compare, is natural: a combinational per-operand priority comparator, instantiated twice (A and B).

Test Plan:
- `add $3,$1,$2` then `sub $4,$3,$5` → when `sub` is in EX, FwdASel = 01 and FwdBSel = 00; Stall never asserts.
- `add $3,...`, `nop`, `or $6,$7,$3` → FwdBSel = 10 when `or` is in EX.
- `lw $8,0($9)` then `add $10,$8,$8` → Stall = Bubble = 1 for exactly one cycle; next EX cycle FwdASel = FwdBSel = 10.
- `add $0,$1,$2` then `sub $4,$0,$0` → both selects 00 (no forwarding of register 0).
- `lw $8` followed by `add $10,$8,$1` with Flush = 1 in the same cycle → Stall = 0, Bubble = 1, FSM stays RUN; with STALL_COUNTER_EN the counter is unchanged.
- Reset asserted during STALL → next cycle selects 00, Stall 0, a subsequent independent instruction gets no forwarding; with STALL_COUNTER_EN, StallCount = 0.
